// File: rtl/mul_seq_nxn.sv
// Iterative radix-2 shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Optional early termination on an exhausted multiplier: define MUL_SEQ_EARLY_TERM_EN.
module mul_seq_nxn #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_out;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_b_nxt;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_result;
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [CNT_W-1:0]     w_shamt;
`endif

    // One shift-add step: the carry of the upper-half add lands in the accumulator MSB.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
        w_acc_nxt = r_acc >> 1;
        w_acc_nxt[2*WIDTH-1:WIDTH-1] = w_sum;
        w_b_nxt   = r_b >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
        // Remaining iterations would only add zero; right-align the partial product in one step.
        w_shamt   = LAST - r_cnt;
        w_last    = (r_cnt == LAST) || (w_b_nxt == '0);
        w_result  = w_acc_nxt >> w_shamt;
`else
        w_last    = (r_cnt == LAST);
        w_result  = w_acc_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out       <= w_result;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Product held until the consumer takes it; out keeps it afterwards.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign busy      = r_busy;

endmodule
